// File: rtl/mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
//
// Contents:
//   state_e      controller states IDLE / BUSY / DONE
//   booth_sel_e  one-hot partial-product select {NEG,POS,NEG2,POS2}; all-zero = add nothing
//   step_count   number of radix-4 steps for a given operand width
//   booth_decode maps a 3-bit Booth window onto a booth_sel_e code

package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit order is {NEG, POS, NEG2, POS2}, so at most one bit is ever set.
   typedef enum logic [3:0] {
      SEL_ZERO = 4'b0000,
      SEL_POS2 = 4'b0001,
      SEL_NEG2 = 4'b0010,
      SEL_POS  = 4'b0100,
      SEL_NEG  = 4'b1000
   } booth_sel_e;

   // Operands are widened by two bits so an unsigned operand stays positive
   // when treated as signed; each step retires two multiplier bits.
   function automatic int step_count(input int width);
      return (width + 2) / 2;
   endfunction

   // Classic radix-4 recoding of {b[2i+1], b[2i], b[2i-1]}.
   function automatic booth_sel_e booth_decode(input logic [2:0] window);
      booth_sel_e sel;
      case (window)
         3'b001, 3'b010: sel = SEL_POS;
         3'b011:         sel = SEL_POS2;
         3'b100:         sel = SEL_NEG2;
         3'b101, 3'b110: sel = SEL_NEG;
         default:        sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector (combinational).
//
// Ports:
//   window  in   3        multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   mcand   in   WIDTH+2  extended multiplicand (two's complement)
//   pp      out  WIDTH+3  selected partial product, one's complement when negative
//   neg     out  1        negate carry; add it at the partial product's LSB to finish -x = ~x + 1

module booth_r4_sel
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       window,
   input  logic [WIDTH+1:0] mcand,
   output logic [WIDTH+2:0] pp,
   output logic             neg
);

   booth_sel_e       sel;
   logic [WIDTH+2:0] mag;

   // Pick 0, A or 2A at WIDTH+3 bits (one extra bit so 2A cannot overflow),
   // then invert for the negative selects and hand the +1 out as the carry.
   always_comb begin
      sel = booth_decode(window);
      mag = '0;
      neg = 1'b0;
      case (sel)
         SEL_POS:  mag = {mcand[WIDTH+1], mcand};
         SEL_NEG: begin
            mag = {mcand[WIDTH+1], mcand};
            neg = 1'b1;
         end
         SEL_POS2: mag = {mcand, 1'b0};
         SEL_NEG2: begin
            mag = {mcand, 1'b0};
            neg = 1'b1;
         end
         default:  mag = '0;
      endcase
      pp = neg ? ~mag : mag;
   end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier, one partial product retired per cycle.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        synchronous reset, active-low
//   flush      in   1        abort the current operation and return to IDLE
//   in_valid   in   1        operands valid
//   in_ready   out  1        block can accept operands (IDLE only)
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   a_signed   in   1        1: a is two's complement, 0: unsigned
//   b_signed   in   1        1: b is two's complement, 0: unsigned
//   out_valid  out  1        product valid (DONE)
//   out_ready  in   1        consumer takes the product
//   product    out  2*WIDTH  full product a*b, zero outside DONE

module booth_r4_seq_mul
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 a_signed,
   input  logic                 b_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int EW = WIDTH + 2;
   localparam int AW = 2 * WIDTH + 2;
   localparam int N  = step_count(WIDTH);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e         state;
   state_e         state_next;
   logic           accept;
   logic           step;

   logic [EW-1:0]  mcand;
   logic [EW:0]    mplier;
   logic [AW-1:0]  acc;
   logic [CW-1:0]  cnt;

   logic [EW:0]    pp;
   logic           pp_neg;
   logic [CW:0]    shamt;
   logic [AW-1:0]  pp_ext;
   logic [AW-1:0]  carry_ext;
   logic [AW-1:0]  acc_next;

   // The multiplier register carries an implicit zero below bit 0, so its
   // low three bits are always the current Booth window.
   booth_r4_sel #(
      .WIDTH (WIDTH)
   ) u_sel (
      .window (mplier[2:0]),
      .mcand  (mcand),
      .pp     (pp),
      .neg    (pp_neg)
   );

   // Sign-extend the partial product to accumulator width, align it to this
   // step's weight 4^cnt and fold in the negate carry at the same weight.
   // Everything wraps modulo 2^AW, which still leaves the low 2*WIDTH bits exact.
   always_comb begin
      shamt     = {cnt, 1'b0};
      pp_ext    = {{(AW-EW-1){pp[EW]}}, pp} << shamt;
      carry_ext = {{(AW-1){1'b0}}, pp_neg} << shamt;
      acc_next  = acc + pp_ext + carry_ext;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode. Flush overrides whatever the current
   // state wanted to do, including an acceptance in the same cycle.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (cnt == LAST) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
         accept     = 1'b0;
         step       = 1'b0;
      end
   end

   // Operand capture and the accumulate loop. The signedness modes are
   // consumed at capture time by choosing sign- or zero-extension, so they
   // need no register of their own.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (flush) begin
         acc    <= '0;
         cnt    <= '0;
      end else if (accept) begin
         mcand  <= a_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
         mplier <= {(b_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b}), 1'b0};
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         acc    <= acc_next;
         cnt    <= cnt + 1'b1;
         mplier <= mplier >> 2;
      end
   end

   // Only present the result while it is valid so the bus reads zero otherwise.
   always_comb begin
      product = (state == DONE) ? acc[2*WIDTH-1:0] : '0;
   end

endmodule
